// File: rtl/pbvi_pkg.sv
// ---------------------------------------------------------------------------
// pbvi_pkg
// Shared sizing constants and types for the PBVI argmax backup scheduler.
//   DW         element width of belief and gamma vectors (unsigned)
//   N_STATES   elements per belief / alpha vector
//   N_POINTS   belief points processed per sweep
//   N_ACTIONS  candidate actions evaluated per point
//   VAL_W      full-precision dot-product width, sized so the sum never wraps
//   PW / AW    point and action address widths (at least one bit each)
//   vec_t      packed vector, element i lives in bits [i*DW +: DW]
//   sched_state_e  scheduler FSM states
// ---------------------------------------------------------------------------
package pbvi_pkg;

  localparam int DW        = 16;
  localparam int N_STATES  = 2;
  localparam int N_POINTS  = 16;
  localparam int N_ACTIONS = 3;

  localparam int VAL_W = 2 * DW + $clog2(N_STATES);
  localparam int PW    = (N_POINTS  > 1) ? $clog2(N_POINTS)  : 1;
  localparam int AW    = (N_ACTIONS > 1) ? $clog2(N_ACTIONS) : 1;

  typedef logic [N_STATES*DW-1:0] vec_t;
  typedef logic [VAL_W-1:0]       val_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_BEL,
    RD_GAM,
    EVAL,
    WR,
    DONE
  } sched_state_e;

endpackage

// File: rtl/pbvi_dot.sv
// ---------------------------------------------------------------------------
// pbvi_dot
// Combinational unsigned dot product of two N_STATES-element vectors.
//   x    in   vec_t   first operand (belief)
//   y    in   vec_t   second operand (gamma)
//   val  out  val_t   sum_i x[i]*y[i], full width, no truncation
// ---------------------------------------------------------------------------
module pbvi_dot
  import pbvi_pkg::*;
(
  input  vec_t x,
  input  vec_t y,
  output val_t val
);

  // Each element is zero-extended to the full result width before the
  // multiply so neither the products nor the running sum can wrap.
  always_comb begin
    val = '0;
    for (int i = 0; i < N_STATES; i++) begin
      val = val + (val_t'(x[i*DW +: DW]) * val_t'(y[i*DW +: DW]));
    end
  end

endmodule

// File: rtl/pbvi_argmax_sched.sv
// ---------------------------------------------------------------------------
// pbvi_argmax_sched
// Sequences the PBVI action-selection backup over every belief point with a
// single shared dot-product unit. For each point the belief is fetched, each
// action's gamma vector is read and scored, the strict argmax is kept (ties
// resolve to the lowest action index) and the winner is written out.
//   clk, rst_n       clock (rising edge), async active-low reset
//   start            begin a sweep, honoured only while idle
//   busy, done       sweep in progress / one-cycle completion pulse
//   bel_rd_*         belief read port, data returns one cycle after strobe
//   gam_rd_*         gamma read port (action, point), one-cycle latency
//   alpha_wr_*       result write port: point, winning vector, winning action
// ---------------------------------------------------------------------------
module pbvi_argmax_sched
  import pbvi_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          bel_rd_en,
  output logic [PW-1:0] bel_rd_point,
  input  vec_t          bel_rd_data,
  output logic          gam_rd_en,
  output logic [AW-1:0] gam_rd_action,
  output logic [PW-1:0] gam_rd_point,
  input  vec_t          gam_rd_data,
  output logic          alpha_wr_en,
  output logic [PW-1:0] alpha_wr_point,
  output vec_t          alpha_wr_data,
  output logic [AW-1:0] alpha_wr_action
);

  localparam logic [PW-1:0] LAST_POINT = PW'(N_POINTS - 1);
  localparam logic [AW-1:0] LAST_ACT   = AW'(N_ACTIONS - 1);

  sched_state_e  state;
  sched_state_e  state_next;
  logic [PW-1:0] point;
  logic [AW-1:0] act;
  logic [AW-1:0] win_act;
  logic [PW-1:0] bel_point_hold;
  logic [PW-1:0] gam_point_hold;
  logic [AW-1:0] gam_act_hold;
  logic [PW-1:0] wr_point_hold;
  vec_t          bel;
  vec_t          alpha;
  val_t          max_val;
  val_t          val;

  // Belief register against the gamma word returned this cycle; only
  // meaningful while in EVAL.
  pbvi_dot u_dot (
    .x   (bel),
    .y   (gam_rd_data),
    .val (val)
  );

  // State register. Reset drops straight to IDLE, so a sweep interrupted by
  // reset is abandoned rather than resumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic. Each point costs RD_BEL + N_ACTIONS*(RD_GAM,EVAL) + WR.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RD_BEL;
      RD_BEL:  state_next = RD_GAM;
      RD_GAM:  state_next = EVAL;
      EVAL:    state_next = (act == LAST_ACT) ? WR : RD_GAM;
      WR:      state_next = (point == LAST_POINT) ? DONE : RD_BEL;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes decode directly from the state, which keeps them mutually
  // exclusive. Addresses show the live counters while their strobe is up
  // and otherwise hold the last value issued.
  assign busy            = (state != IDLE);
  assign done            = (state == DONE);
  assign bel_rd_en       = (state == RD_BEL);
  assign gam_rd_en       = (state == RD_GAM);
  assign alpha_wr_en     = (state == WR);
  assign bel_rd_point    = bel_rd_en   ? point : bel_point_hold;
  assign gam_rd_point    = gam_rd_en   ? point : gam_point_hold;
  assign gam_rd_action   = gam_rd_en   ? act   : gam_act_hold;
  assign alpha_wr_point  = alpha_wr_en ? point : wr_point_hold;
  assign alpha_wr_data   = alpha;
  assign alpha_wr_action = win_act;

  // Counters, belief capture and the running argmax. The first action of a
  // point loads the winner unconditionally; later actions replace it only on
  // a strictly larger score, so equal scores keep the lower action index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      point          <= '0;
      act            <= '0;
      win_act        <= '0;
      bel_point_hold <= '0;
      gam_point_hold <= '0;
      gam_act_hold   <= '0;
      wr_point_hold  <= '0;
      bel            <= '0;
      alpha          <= '0;
      max_val        <= '0;
    end else begin
      case (state)
        RD_BEL: begin
          act            <= '0;
          bel_point_hold <= point;
        end
        RD_GAM: begin
          if (act == '0) bel <= bel_rd_data;
          gam_point_hold <= point;
          gam_act_hold   <= act;
        end
        EVAL: begin
          if ((act == '0) || (val > max_val)) begin
            max_val <= val;
            alpha   <= gam_rd_data;
            win_act <= act;
          end
          act <= act + AW'(1);
        end
        WR: begin
          wr_point_hold <= point;
          point         <= point + PW'(1);
        end
        DONE: begin
          point <= '0;
          act   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pbvi_argmax_sched.sv
// ---------------------------------------------------------------------------
// tb_pbvi_argmax_sched
// Self-checking bench for pbvi_argmax_sched: directed vector table, reset,
// handshake and mid-sweep reset sequences, and randomized sweeps scored by a
// behavioural argmax model working on plain integers.
// ---------------------------------------------------------------------------
module tb_pbvi_argmax_sched;
  import pbvi_pkg::*;

  localparam int SWEEP_CYCLES = 1 + N_POINTS * (2 + 2 * N_ACTIONS);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic          bel_rd_en;
  logic [PW-1:0] bel_rd_point;
  vec_t          bel_rd_data = '0;
  logic          gam_rd_en;
  logic [AW-1:0] gam_rd_action;
  logic [PW-1:0] gam_rd_point;
  vec_t          gam_rd_data = '0;
  logic          alpha_wr_en;
  logic [PW-1:0] alpha_wr_point;
  vec_t          alpha_wr_data;
  logic [AW-1:0] alpha_wr_action;

  always #5 clk = ~clk;

  pbvi_argmax_sched dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .bel_rd_en       (bel_rd_en),
    .bel_rd_point    (bel_rd_point),
    .bel_rd_data     (bel_rd_data),
    .gam_rd_en       (gam_rd_en),
    .gam_rd_action   (gam_rd_action),
    .gam_rd_point    (gam_rd_point),
    .gam_rd_data     (gam_rd_data),
    .alpha_wr_en     (alpha_wr_en),
    .alpha_wr_point  (alpha_wr_point),
    .alpha_wr_data   (alpha_wr_data),
    .alpha_wr_action (alpha_wr_action)
  );

  // Belief and gamma memories with a fixed one-cycle read latency.
  vec_t bel_mem [N_POINTS];
  vec_t gam_mem [N_ACTIONS][N_POINTS];

  always @(posedge clk) begin
    if (bel_rd_en) bel_rd_data <= bel_mem[int'(bel_rd_point)];
    if (gam_rd_en) gam_rd_data <= gam_mem[int'(gam_rd_action)][int'(gam_rd_point)];
  end

  int errors = 0;
  int checks = 0;

  int   wr_pt  [$];
  int   wr_act [$];
  vec_t wr_data[$];
  int   done_cyc;
  bit   excl_bad;

  typedef struct {
    vec_t bel;
    vec_t g0;
    vec_t g1;
    vec_t g2;
    int   exp_act;
    vec_t exp_data;
  } vec_rec_t;

  vec_rec_t tbl [8];

  // Watchdog so a stuck DUT still ends the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input int e0, input int e1);
    vec_t v;
    v = '0;
    v[0 +: DW]  = e0[DW-1:0];
    v[DW +: DW] = e1[DW-1:0];
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Behavioural argmax: score every action with integer arithmetic and keep
  // the first strictly best one.
  function automatic void refBest(input int p, output int best_a, output vec_t best_g);
    longint best_v;
    longint v;
    best_v = 0;
    best_a = 0;
    best_g = '0;
    for (int a = 0; a < N_ACTIONS; a++) begin
      v = 0;
      for (int i = 0; i < N_STATES; i++)
        v += longint'(bel_mem[p][i*DW +: DW]) * longint'(gam_mem[a][p][i*DW +: DW]);
      if (a == 0 || v > best_v) begin
        best_v = v;
        best_a = a;
        best_g = gam_mem[a][p];
      end
    end
  endfunction

  // Runs one sweep from the current (IDLE) cycle, collecting writes and
  // optionally re-pulsing start in the listed cycles of the sweep.
  task automatic applyStimulus(input int pa, input int pb, input int pc);
    wr_pt.delete();
    wr_act.delete();
    wr_data.delete();
    done_cyc = -1;
    excl_bad = 0;
    start = 1'b1;
    for (int c = 1; c <= 3 * SWEEP_CYCLES; c++) begin
      @(posedge clk);
      @(negedge clk);
      start = (c == pa || c == pb || c == pc);
      if ((int'(bel_rd_en) + int'(gam_rd_en) + int'(alpha_wr_en)) > 1 || !busy) excl_bad = 1;
      if (alpha_wr_en) begin
        wr_pt.push_back(int'(alpha_wr_point));
        wr_act.push_back(int'(alpha_wr_action));
        wr_data.push_back(alpha_wr_data);
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    checkOutput("done_seen", 64'(done_cyc >= 0), 64'd1);
  endtask

  task automatic checkSweep(input string tag);
    int   ea;
    vec_t eg;
    checkOutput({tag, "_done_cycle"}, 64'(done_cyc), 64'(SWEEP_CYCLES));
    checkOutput({tag, "_num_writes"}, 64'(wr_pt.size()), 64'(N_POINTS));
    checkOutput({tag, "_strobe_excl"}, 64'(excl_bad), 64'd0);
    for (int i = 0; i < wr_pt.size() && i < N_POINTS; i++) begin
      refBest(i, ea, eg);
      checkOutput($sformatf("%s_pt%0d", tag, i), 64'(wr_pt[i]), 64'(i));
      checkOutput($sformatf("%s_act%0d", tag, i), 64'(wr_act[i]), 64'(ea));
      checkOutput($sformatf("%s_data%0d", tag, i), 64'(wr_data[i]), 64'(eg));
    end
  endtask

  // Step from the done cycle into the following idle cycle.
  task automatic settle();
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idleCheck(input string tag, input int n);
    bit bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy || done || bel_rd_en || gam_rd_en || alpha_wr_en) bad = 1;
    end
    checkOutput({tag, "_quiet"}, 64'(bad), 64'd0);
  endtask

  task automatic fillRandom(input int maxv);
    for (int p = 0; p < N_POINTS; p++) begin
      bel_mem[p] = mk($urandom_range(0, maxv), $urandom_range(0, maxv));
      for (int a = 0; a < N_ACTIONS; a++)
        gam_mem[a][p] = mk($urandom_range(0, maxv), $urandom_range(0, maxv));
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_strobes"}, 64'({bel_rd_en, gam_rd_en, alpha_wr_en}), 64'd0);
    checkOutput({tag, "_addrs"},
                64'({bel_rd_point, gam_rd_point, gam_rd_action, alpha_wr_point, alpha_wr_action}), 64'd0);
    checkOutput({tag, "_wr_data"}, 64'(alpha_wr_data), 64'd0);
  endtask

  initial begin
    int n_pre;

    tbl[0] = '{mk(1, 0),         mk(10, 0),         mk(5, 0),          mk(5, 0),          0, mk(10, 0)};
    tbl[1] = '{mk(1, 0),         mk(5, 0),          mk(10, 0),         mk(5, 0),          1, mk(10, 0)};
    tbl[2] = '{mk(0, 1),         mk(0, 3),          mk(9, 2),          mk(1, 4),          2, mk(1, 4)};
    tbl[3] = '{mk(3, 4),         mk(7, 7),          mk(7, 7),          mk(7, 7),          0, mk(7, 7)};
    tbl[4] = '{mk('hFFFF,'hFFFF), mk('hFFFF,'hFFFE), mk('hFFFF,'hFFFF), mk('hFFFF,'hFFFE), 1, mk('hFFFF,'hFFFF)};
    tbl[5] = '{mk(2, 3),         mk(1, 1),          mk(0, 2),          mk(3, 0),          1, mk(0, 2)};
    tbl[6] = '{mk(0, 0),         mk(11, 22),        mk(33, 44),        mk(55, 66),        0, mk(11, 22)};
    tbl[7] = '{mk(1, 1),         mk(0, 0),          mk(0, 1),          mk(2, 0),          2, mk(2, 0)};

    // Reset held with start asserted: everything stays at zero.
    for (int p = 0; p < N_POINTS; p++) begin
      bel_mem[p] = '0;
      for (int a = 0; a < N_ACTIONS; a++) gam_mem[a][p] = '0;
    end
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    start = 1'b0;
    idleCheck("post_reset", 5);

    // Directed vector table, point p uses row p%8.
    $display("[TB] directed vector table");
    for (int p = 0; p < N_POINTS; p++) begin
      bel_mem[p]    = tbl[p % 8].bel;
      gam_mem[0][p] = tbl[p % 8].g0;
      gam_mem[1][p] = tbl[p % 8].g1;
      gam_mem[2][p] = tbl[p % 8].g2;
    end
    applyStimulus(0, 0, 0);
    checkOutput("tbl_done_cycle", 64'(done_cyc), 64'(SWEEP_CYCLES));
    checkOutput("tbl_num_writes", 64'(wr_pt.size()), 64'(N_POINTS));
    for (int i = 0; i < wr_pt.size() && i < N_POINTS; i++) begin
      checkOutput($sformatf("tbl_pt%0d", i),   64'(wr_pt[i]),   64'(i));
      checkOutput($sformatf("tbl_act%0d", i),  64'(wr_act[i]),  64'(tbl[i % 8].exp_act));
      checkOutput($sformatf("tbl_data%0d", i), 64'(wr_data[i]), 64'(tbl[i % 8].exp_data));
    end
    settle();

    // Rotating argmax: action p%3 scores 10, the others 5.
    $display("[TB] rotating argmax sweep");
    for (int p = 0; p < N_POINTS; p++) begin
      bel_mem[p] = mk(1, 0);
      for (int a = 0; a < N_ACTIONS; a++) gam_mem[a][p] = mk((a == p % 3) ? 10 : 5, 0);
    end
    applyStimulus(0, 0, 0);
    checkOutput("rot_done_cycle", 64'(done_cyc), 64'(SWEEP_CYCLES));
    checkOutput("rot_num_writes", 64'(wr_pt.size()), 64'(N_POINTS));
    for (int i = 0; i < wr_pt.size() && i < N_POINTS; i++) begin
      checkOutput($sformatf("rot_act%0d", i),  64'(wr_act[i]),  64'(i % 3));
      checkOutput($sformatf("rot_data%0d", i), 64'(wr_data[i]), 64'(mk(10, 0)));
    end
    settle();

    // All-tie sweep.
    for (int p = 0; p < N_POINTS; p++) begin
      bel_mem[p] = mk(3, 4);
      for (int a = 0; a < N_ACTIONS; a++) gam_mem[a][p] = mk(7, 7);
    end
    applyStimulus(0, 0, 0);
    checkSweep("tie");
    settle();

    // Handshake: stray starts mid-sweep and in the done cycle are ignored,
    // a start in the cycle after done begins the next sweep.
    $display("[TB] handshake sequence");
    fillRandom(65535);
    applyStimulus(5, 60, SWEEP_CYCLES);
    checkSweep("hs1");
    @(posedge clk);
    @(negedge clk);
    checkOutput("hs_idle_after_done", 64'(busy), 64'd0);
    applyStimulus(0, 0, 0);
    checkSweep("hs2");
    settle();
    idleCheck("hs_after", 10);

    // Reset during EVAL of point 7 abandons the sweep.
    $display("[TB] mid-sweep reset");
    fillRandom(65535);
    wr_pt.delete();
    start = 1'b1;
    for (int c = 1; c <= 1 + 7 * (2 + 2 * N_ACTIONS) + 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (alpha_wr_en) wr_pt.push_back(int'(alpha_wr_point));
    end
    n_pre = wr_pt.size();
    checkOutput("mr_writes_before", 64'(n_pre), 64'd7);
    rst_n = 1'b0;
    #1;
    checkAllZero("mr_in_reset");
    excl_bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (alpha_wr_en || busy) excl_bad = 1;
    end
    checkOutput("mr_no_write_in_reset", 64'(excl_bad), 64'd0);
    rst_n = 1'b1;
    idleCheck("mr_after_release", 3);
    applyStimulus(0, 0, 0);
    checkSweep("mr_restart");
    settle();

    // Randomized sweeps, small ranges make ties common.
    $display("[TB] randomized sweeps");
    for (int r = 0; r < 4; r++) begin
      fillRandom((r % 2 == 0) ? 3 : 65535);
      applyStimulus(0, 0, 0);
      checkSweep($sformatf("rnd%0d", r));
      settle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
